pe_seq: RTL

Operand sequencer and result collector that sits in front of one `pe_unit`. It drives the PE's operand, slot-select and round-enable inputs, and issues a one-cycle PE clear before each job. It captures each rounded slot result from the PE output at the correct pipeline cycle and returns it through a valid/ready result port. It is the initiator/reader for the PE's accumulate-and-round interface.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_res_fifo.sv | 65 ++++++
 rtl/pe_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the pe_seq operand sequencer / result collector.
//   DW        : default operand width (Q7.9)
//   PE_LAT    : pe_unit round-request to rounded-output latency, cycles
//   NUM_SLOTS : accumulator slots in one pe_unit
//   RES_DEPTH : result FIFO depth
package pe_pkg;
  localparam int DW        = 16;
  localparam int PE_LAT    = 3;
  localparam int NUM_SLOTS = 8;
  localparam int RES_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } pe_seq_state_t;
endpackage

// File: rtl/pe_res_fifo.sv
// Synchronous FIFO holding {slot, data} result entries.
//   push/push_data : write side; accepted when not full, or when full and
//                    popping in the same cycle (count then stays put)
//   pop            : read side; ignored when empty
//   head/empty     : current head entry and empty flag
//   count          : number of stored entries
module pe_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) rd_d = ptr_inc(rd_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/pe_seq.sv
// Operand sequencer and result collector in front of one pe_unit.
//   start/cfg_len/cfg_slots : job request (sampled in IDLE)
//   busy/done/err           : job status; done (+err on bad config) pulse
//   op_*                    : operand stream, one beat per op_valid&op_ready
//   res_*                   : rounded results, ascending slot order
//   pe_*                    : pe_unit drive (clear, operands, slot, round)
//                             and its rounded output
// Optional macro PE_SEQ_PERF_EN adds perf_stall[15:0]: RUN cycles without
// a beat, saturating, cleared on entry to CLEAR.
module pe_seq
  import pe_pkg::*;
#(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int LEN_W          = 8,
  localparam int DATA_W        = para_int_bits + para_frac_bits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [3:0]        cfg_slots,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [2:0]        res_slot,
  output logic              pe_rst_n,
  output logic [DATA_W-1:0] pe_data_in_1,
  output logic [DATA_W-1:0] pe_data_in_2,
  output logic [3:0]        pe_add_number,
  output logic              pe_rounder_en,
  input  logic [DATA_W-1:0] pe_data_out
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_stall
`endif
);
  localparam int FW = 3 + DATA_W;
  localparam int CW = $clog2(RES_DEPTH + 1);

  pe_seq_state_t           state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d, term_q, term_d;
  logic [3:0]              slots_q, slots_d;
  logic [2:0]              slot_q, slot_d, add_q, add_d;
  logic [PE_LAT:1]         vld_pipe_q, vld_pipe_d;
  logic [PE_LAT:1][2:0]    slot_pipe_q, slot_pipe_d;
  logic                    beat, last_term, last_slot, cfg_bad, clr;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [FW-1:0]           fifo_head;
  logic [3:0]              occ;

  assign cfg_bad   = (len_q == '0) || (slots_q == 4'd0) || (slots_q > 4'(NUM_SLOTS));
  assign last_term = (term_q == len_q - LEN_W'(1));
  assign last_slot = ({1'b0, slot_q} == slots_q - 4'd1);

  // Results already queued plus rounds still travelling through the PE.
  // Holding this below the FIFO depth guarantees every capture finds room.
  assign occ      = 4'(fifo_count) + 4'($countones(vld_pipe_q));
  assign op_ready = (state_q == ST_RUN) && (occ < 4'(RES_DEPTH));
  assign beat     = op_valid && op_ready;

  // Off-beat cycles feed a zero product so the selected slot is unchanged.
  assign pe_data_in_1  = beat ? op_a : '0;
  assign pe_data_in_2  = beat ? op_b : '0;
  assign pe_add_number = {1'b0, beat ? slot_q : add_q};
  assign pe_rounder_en = beat && last_term;

  assign clr      = (state_q == ST_CLEAR) && !cfg_bad;
  assign pe_rst_n = rst_n & ~clr;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_DONE) && cfg_bad;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    slots_d = slots_q;
    slot_d  = slot_q;
    term_d  = term_q;
    add_d   = add_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_CLEAR;
        len_d   = cfg_len;
        slots_d = cfg_slots;
        slot_d  = '0;
        term_d  = '0;
      end
      ST_CLEAR: state_d = cfg_bad ? ST_DONE : ST_RUN;
      ST_RUN: if (beat) begin
        add_d = slot_q;
        if (last_term) begin
          term_d = '0;
          if (last_slot) state_d = ST_DRAIN;
          else           slot_d  = slot_q + 3'd1;
        end else begin
          term_d = term_q + LEN_W'(1);
        end
      end
      ST_DRAIN: if (vld_pipe_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture pipe mirrors the PE's round latency: stage PE_LAT lines up
  // with the rounded value on pe_data_out.
  always_comb begin
    vld_pipe_d  = {vld_pipe_q[PE_LAT-1:1], pe_rounder_en};
    slot_pipe_d = {slot_pipe_q[PE_LAT-1:1], pe_add_number[2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      slots_q     <= '0;
      slot_q      <= '0;
      term_q      <= '0;
      add_q       <= '0;
      vld_pipe_q  <= '0;
      slot_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      slots_q     <= slots_d;
      slot_q      <= slot_d;
      term_q      <= term_d;
      add_q       <= add_d;
      vld_pipe_q  <= vld_pipe_d;
      slot_pipe_q <= slot_pipe_d;
    end
  end

  pe_res_fifo #(.DEPTH(RES_DEPTH), .W(FW)) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe_q[PE_LAT]),
    .push_data ({slot_pipe_q[PE_LAT], pe_data_out}),
    .pop       (res_valid && res_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign res_slot  = fifo_empty ? '0 : fifo_head[FW-1:DATA_W];

`ifdef PE_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && state_d == ST_CLEAR) stall_d = '0;
    else if (state_q == ST_RUN && !beat && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end
  assign perf_stall = stall_q;
`else
  // Stall counter not built.
`endif
endmodule
